sort_verify: RTL and testbench
==============================

# sort_verify

Read-back checker for the sorting datapath. After the sorter finishes, it scans the first `length` bytes of the shared on-chip memory through the same single-port interface the sorter uses. It reports whether the data is non-decreasing, the first out-of-order index, and the min, max and sum. It is a second memory master behind the top-level controller and uses the sorter's `enable`/`ready` handshake.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 8, memory word width
- LEN_W, 10, width of the length input
- SUM_W, 16, width of the sum accumulator

Ports:
- clk  in  1  system clock (50 MHz); single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  start request; sampled only while `ready`=1
- ready  out  1  1 = idle and results valid
- done  out  1  one-cycle pulse when a scan completes
- length  in  LEN_W  number of words to scan, sampled on accepted `enable`
- rdata  in  DATA_W  memory read data, valid one cycle after `address`
- address  out  ADDR_W  memory address
- wren  out  1  memory write enable; constant 0
- sorted  out  1  1 = scanned region is non-decreasing
- err_idx  out  ADDR_W  first index i where mem[i] < mem[i-1]; 0 when `sorted`=1
- min_val  out  DATA_W  smallest word scanned
- max_val  out  DATA_W  largest word scanned
- sum  out  SUM_W  sum of scanned words

## Operation
- Reset values: ready=1, done=0, address=0, wren=0, sorted=0, err_idx=0, min_val=0, max_val=0, sum=0, state IDLE.
- An enable is accepted when `enable`=1 and `ready`=1 at a clock edge.
  - On acceptance, latch the clamped length: n = min(length, 256).
- If n=0:
  - No memory access occurs and `ready` stays 1.
  - Next cycle: done=1, sorted=1, err_idx=0, min_val=0, max_val=0, sum=0.
- If n>0, the block moves IDLE → PRIME → SCAN → IDLE.
  - IDLE: `ready`=1 and `address` holds its last value.
  - PRIME (1 cycle): ready=0 and address=0. Clear the results to sorted=1, err_idx=0, min_val=FF, max_val=00, sum=0. Clear the index i to 0.
  - SCAN (n cycles): address = i+1 (prefetch) and `rdata` = mem[i]. Each cycle consumes `rdata`:
    - min/max update;
    - sum += rdata (zero-extended);
    - if i>0, rdata < prev and sorted=1, then set sorted=0 and err_idx=i (only the first violation is recorded);
    - prev <= rdata; i++.
  - When i = n-1 is consumed, go to IDLE with done=1 for one cycle and ready=1.
- The prefetch address wraps 255 → 0 when n=256. The extra read is discarded.
- `enable` while busy (ready=0) is ignored. `length` changes during a scan have no effect.
- Results hold until the next accepted enable.
- Asynchronous reset at any time, including mid-scan, forces the reset values immediately. No partial results are retained.
- Arithmetic is unsigned. The sum cannot overflow: 256×255 = 65280 < 2^16.

## Timing
- Accepted enable at edge E0 with n>0:
  - PRIME in cycle 1.
  - SCAN in cycles 2..n+1.
  - `ready` and `done` are 1 in cycle n+2.
- Total busy time: n+1 cycles.
- Memory model: synchronous RAM with a registered address. Data for the address driven in cycle k appears on `rdata` in cycle k+1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `done` and `ready` rise in the same cycle. Results are stable in that cycle.

## Structure
- Shared package `sort_pkg` holds:
  - ADDR_W, DATA_W, LEN_W, MAX_LEN=256;
  - the state enum typedef (IDLE, PRIME, SCAN), reusable by other memory masters.
- Sub-module `sort_verify_stats` holds the per-word accumulator: min, max, sum and order check, with clear/consume inputs. The top level holds the FSM, address counter and length clamp.
- The top-level address/wren mux between the sorter and `sort_verify` is outside this block.

## Test plan
- Memory [1,2,2,5], length=4 → sorted=1, err_idx=0, min_val=1, max_val=5, sum=10. done in cycle 6 after the enable edge.
- Memory [3,1,2,0], length=4 → sorted=0, err_idx=1, min_val=0, max_val=3, sum=6.
- length=0 → no address change and ready stays 1. done in the next cycle with sorted=1 and sum=0.
- Memory[i]=i for all 256 words, length=1023 → clamped to 256, sorted=1, min_val=0, max_val=255, sum=32640. Address wraps to 0 on the last prefetch.
- enable pulsed again and length changed mid-scan → ignored. Results match the original length. wren stays 0 throughout.
- rst_n low during SCAN → ready=1, sorted=0, sum=0 immediately. A fresh enable then completes normally.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, state encoding and length clamp for memory masters
package sort_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 10;
  localparam int SUM_W   = 16;
  localparam int MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // A request longer than the memory scans the whole memory once.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/sort_verify_if.sv
// rtl/sort_verify_if.sv - handshake, memory port and result bus of the read-back checker
interface sort_verify_if;
  import sort_pkg::*;

  logic              enable;
  logic              ready;
  logic              done;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address;
  logic              wren;
  logic              sorted;
  logic [ADDR_W-1:0] err_idx;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [SUM_W-1:0]  sum;

  modport master (
    output enable, length, rdata,
    input  ready, done, address, wren, sorted, err_idx, min_val, max_val, sum
  );

  modport slave (
    input  enable, length, rdata,
    output ready, done, address, wren, sorted, err_idx, min_val, max_val, sum
  );

endinterface

// File: rtl/sort_verify_stats.sv
// rtl/sort_verify_stats.sv - per-word accumulator: min, max, sum and first order violation
module sort_verify_stats
  import sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_zero,
  input  logic              i_clr,
  input  logic              i_consume,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_sorted,
  output logic [ADDR_W-1:0] o_err_idx,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic [SUM_W-1:0]  o_sum
);

  logic              r_sorted;
  logic [ADDR_W-1:0] r_err_idx;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sorted  <= 1'b0;
      r_err_idx <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_sum     <= '0;
      r_prev    <= '0;
    end else if (i_zero) begin
      r_sorted  <= 1'b1;
      r_err_idx <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_sum     <= '0;
    end else if (i_clr) begin
      // Extreme seeds so the first consumed word always replaces both.
      r_sorted  <= 1'b1;
      r_err_idx <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_sum     <= '0;
    end else if (i_consume) begin
      if (i_data < r_min) r_min <= i_data;
      if (i_data > r_max) r_max <= i_data;
      r_sum <= r_sum + SUM_W'(i_data);
      if ((i_idx != '0) && (i_data < r_prev) && r_sorted) begin
        r_sorted  <= 1'b0;
        r_err_idx <= i_idx;
      end
      r_prev <= i_data;
    end
  end

  assign o_sorted  = r_sorted;
  assign o_err_idx = r_err_idx;
  assign o_min     = r_min;
  assign o_max     = r_max;
  assign o_sum     = r_sum;

endmodule

// File: rtl/sort_verify.sv
// rtl/sort_verify.sv - read-back checker: FSM, prefetch address counter and length clamp
module sort_verify
  import sort_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  sort_verify_if.slave bus
);

  state_t            r_state;
  logic              r_ready;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;

  logic              w_accept;
  logic [LEN_W-1:0]  w_n;
  logic              w_empty;

  assign w_accept = bus.enable & r_ready;
  assign w_n      = clamp_len(bus.length);
  assign w_empty  = (w_n == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_last  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_empty) begin
              r_done <= 1'b1;
            end else begin
              r_state <= PRIME;
              r_ready <= 1'b0;
              r_addr  <= '0;
              r_last  <= ADDR_W'(w_n - LEN_W'(1));
            end
          end
        end
        PRIME: begin
          r_state <= SCAN;
          r_idx   <= '0;
          r_addr  <= ADDR_W'(1);
        end
        SCAN: begin
          if (r_idx == r_last) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            // Prefetch one word ahead; wraps 255 -> 0 on a full-memory scan.
            r_idx  <= r_idx + ADDR_W'(1);
            r_addr <= r_idx + ADDR_W'(2);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  sort_verify_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_zero    (w_accept & w_empty),
    .i_clr     (r_state == PRIME),
    .i_consume (r_state == SCAN),
    .i_idx     (r_idx),
    .i_data    (bus.rdata),
    .o_sorted  (bus.sorted),
    .o_err_idx (bus.err_idx),
    .o_min     (bus.min_val),
    .o_max     (bus.max_val),
    .o_sum     (bus.sum)
  );

  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.address = r_addr;
  assign bus.wren    = 1'b0;

endmodule

// File: tb/tb_sort_verify.sv
// tb/tb_sort_verify.sv - directed vectors for sort_verify against a synchronous RAM model
module tb_sort_verify;

  logic clk;
  logic rst_n;
  logic wren_seen;
  logic [7:0] mem [0:255];
  int n_tests;
  int n_fail;
  int cyc;

  sort_verify_if bus ();

  sort_verify u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) bus.rdata <= mem[bus.address];

  always @(negedge clk) if (bus.wren !== 1'b0) wren_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input int srt, input int err,
                               input int mn, input int mx, input int sm);
    check({tag, ".sorted"},  32'(bus.sorted),  32'(srt));
    check({tag, ".err_idx"}, 32'(bus.err_idx), 32'(err));
    check({tag, ".min"},     32'(bus.min_val), 32'(mn));
    check({tag, ".max"},     32'(bus.max_val), 32'(mx));
    check({tag, ".sum"},     32'(bus.sum),     32'(sm));
  endtask

  // Leaves the bench at the falling edge inside cycle 1 after the accepting edge.
  task automatic start(input logic [9:0] len);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.length = len;
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (bus.done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    wren_seen  = 1'b0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;

    repeat (2) @(negedge clk);
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.address", 32'(bus.address), 32'd0);
    check_results("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Sorted with a repeated value
    load4(8'd1, 8'd2, 8'd2, 8'd5);
    start(10'd4);
    check("t1.prime_ready", 32'(bus.ready), 32'd0);
    check("t1.prime_addr", 32'(bus.address), 32'd0);
    @(negedge clk);
    check("t1.scan_addr", 32'(bus.address), 32'd1);
    wait_done(2, cyc);
    check("t1.done_cycle", 32'(cyc), 32'd6);
    check("t1.ready", 32'(bus.ready), 32'd1);
    check_results("t1", 1, 0, 1, 5, 10);
    @(negedge clk);
    check("t1.done_pulse", 32'(bus.done), 32'd0);

    // Two violations; only the first is recorded
    load4(8'd3, 8'd1, 8'd2, 8'd0);
    start(10'd4);
    wait_done(1, cyc);
    check("t2.done_cycle", 32'(cyc), 32'd6);
    check_results("t2", 0, 1, 0, 3, 6);
    check("t2.addr_hold", 32'(bus.address), 32'd4);

    // Zero length: no memory access, done next cycle
    start(10'd0);
    check("t3.done", 32'(bus.done), 32'd1);
    check("t3.ready", 32'(bus.ready), 32'd1);
    check("t3.addr", 32'(bus.address), 32'd4);
    check_results("t3", 1, 0, 0, 0, 0);
    @(negedge clk);
    check("t3.done_pulse", 32'(bus.done), 32'd0);

    // Oversized length clamps to the full memory
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start(10'd1023);
    wait_done(1, cyc);
    check("t4.done_cycle", 32'(cyc), 32'd258);
    check_results("t4", 1, 0, 0, 255, 32640);
    check("t4.addr_wrap", 32'(bus.address), 32'd0);

    // Enable and length changes while busy are ignored
    mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd4;
    mem[3] = 8'd4; mem[4] = 8'd9; mem[5] = 8'd1;
    start(10'd6);
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    bus.length = 10'd2;
    @(negedge clk);
    bus.enable = 1'b0;
    check("t5.busy", 32'(bus.ready), 32'd0);
    wait_done(4, cyc);
    check("t5.done_cycle", 32'(cyc), 32'd8);
    check_results("t5", 0, 2, 1, 9, 29);
    bus.length = 10'd0;
    repeat (3) @(negedge clk);
    check("t5.idle_after", 32'(bus.ready), 32'd1);
    check_results("t5.hold", 0, 2, 1, 9, 29);

    // Asynchronous reset mid-scan, then a clean rerun
    load4(8'd1, 8'd2, 8'd2, 8'd5);
    start(10'd4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.rst_ready", 32'(bus.ready), 32'd1);
    check("t6.rst_addr", 32'(bus.address), 32'd0);
    check_results("t6.rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start(10'd4);
    wait_done(1, cyc);
    check("t6.done_cycle", 32'(cyc), 32'd6);
    check_results("t6", 1, 0, 1, 5, 10);

    check("wren_never", 32'(wren_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
